uart_rx_controller: RTL

Frame-level sequencer for the UART receive path. Synchronises the raw Rx line and detects the start-bit falling edge. Kicks the `sampling_strobe_generator` through `start_detected`, then uses each `sampling_strobe` pulse to walk the start, data, optional parity and stop bits. Delivers received bytes through a valid/ack holding register with framing, parity and overrun flags.

---
 rtl/uart_pkg.sv | 18 +
 rtl/rx_input_sync.sv | 30 +++
 rtl/uart_rx_controller.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// RX_PARITY_EN adds the PARITY state encoding.
package uart_pkg;

  localparam int unsigned DATA_BITS_DEFAULT = 8;
  localparam logic        RX_IDLE_LEVEL     = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } rx_state_e;

endpackage

// File: rtl/rx_input_sync.sv
// Two-flop synchroniser for the raw Rx line plus a falling-edge detector.
module rx_input_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic rx_serial,
  output logic rx_sync,
  output logic fall_edge_c
);

  logic rx_meta;
  logic rx_prev;

  // Flops reset to the idle level so reset itself never looks like a start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= RX_IDLE_LEVEL;
      rx_sync <= RX_IDLE_LEVEL;
      rx_prev <= RX_IDLE_LEVEL;
    end else begin
      rx_meta <= rx_serial;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign fall_edge_c = rx_prev & ~rx_sync;

endmodule

// File: rtl/uart_rx_controller.sv
// UART receive frame sequencer with valid/ack holding register and error pulses.
// Define RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_controller
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = DATA_BITS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_serial,
  input  logic                 sampling_strobe,
  output logic                 start_detected,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 busy,
  output logic                 framing_error,
  output logic                 parity_error,
  output logic                 overrun_error
);

  localparam int unsigned CNT_W = $clog2(DATA_BITS + 1);

  rx_state_e            state, state_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic                 start_n, load_n, ferr_n;
  logic                 rx_sync, fall_edge_c;
`ifdef RX_PARITY_EN
  logic                 par_bad, par_bad_n, perr_n;
`endif

  rx_input_sync u_sync (
    .clk         (clk),
    .reset       (reset),
    .rx_serial   (rx_serial),
    .rx_sync     (rx_sync),
    .fall_edge_c (fall_edge_c)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    shift_n = shift;
    cnt_n   = cnt;
    start_n = 1'b0;
    load_n  = 1'b0;
    ferr_n  = 1'b0;
`ifdef RX_PARITY_EN
    par_bad_n = par_bad;
    perr_n    = 1'b0;
`endif
    unique case (state)
      ST_IDLE: begin
        if (fall_edge_c) begin
          start_n = 1'b1;
          state_n = ST_START;
        end
      end
      ST_START: begin
        if (sampling_strobe) begin
          if (!rx_sync) begin
            cnt_n   = '0;
            state_n = ST_DATA;
`ifdef RX_PARITY_EN
            par_bad_n = 1'b0;
`endif
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        // Right shift with new bit at MSB: the LSB-first frame lands in order.
        if (sampling_strobe) begin
          shift_n = {rx_sync, shift[DATA_BITS-1:1]};
          cnt_n   = cnt + CNT_W'(1);
          if (cnt == CNT_W'(DATA_BITS - 1)) begin
`ifdef RX_PARITY_EN
            state_n = ST_PARITY;
`else
            state_n = ST_STOP;
`endif
          end
        end
      end
`ifdef RX_PARITY_EN
      ST_PARITY: begin
        if (sampling_strobe) begin
          par_bad_n = rx_sync ^ (^shift);
          state_n   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (sampling_strobe) begin
          state_n = ST_IDLE;
          ferr_n  = ~rx_sync;
`ifdef RX_PARITY_EN
          perr_n  = par_bad;
          load_n  = rx_sync & ~par_bad;
`else
          load_n  = rx_sync;
`endif
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift          <= '0;
      cnt            <= '0;
      start_detected <= 1'b0;
      busy           <= 1'b0;
      rx_data        <= '0;
      rx_valid       <= 1'b0;
      framing_error  <= 1'b0;
      overrun_error  <= 1'b0;
    end else begin
      shift          <= shift_n;
      cnt            <= cnt_n;
      start_detected <= start_n;
      busy           <= (state_n != ST_IDLE);
      framing_error  <= ferr_n;
      overrun_error  <= load_n & rx_valid & ~rx_ack;
      // A load coincident with an ack simply replaces the acknowledged byte.
      if (load_n) begin
        rx_data  <= shift;
        rx_valid <= 1'b1;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      par_bad      <= 1'b0;
      parity_error <= 1'b0;
    end else begin
      par_bad      <= par_bad_n;
      parity_error <= perr_n;
    end
  end
`else
  assign parity_error = 1'b0;
`endif

endmodule
